// File: rtl/fact_pkg.sv
// Shared definitions for the iterative factorial control unit and datapath.
package fact_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_MUL  = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } fact_state_t;

   // Largest operand whose factorial fits the 32-bit product register.
   localparam int FACT_MAX_N = 12;
   localparam int RES_W      = 32;

   localparam logic SEL_ONE  = 1'b1;
   localparam logic SEL_MULT = 1'b0;

endpackage

// File: rtl/fact_cu_if.sv
// Host handshake plus control/status bundle between fact_cu (master) and the datapath (slave).
interface fact_cu_if
   import fact_pkg::*;
#(
   parameter int NW = 4
);
   logic             Go;
   logic [NW-1:0]    n_in;
   logic             Busy;
   logic             Done;
   logic             Error;

   logic [NW-1:0]    n;
   logic             Ld_CNT;
   logic             EN;
   logic             Sel;
   logic             LdR;
   logic             OE;
   logic             GT12;
   logic             GT1;
   logic [RES_W-1:0] RESULT;

   modport master (
      input  Go, n_in, GT12, GT1,
      output n, Ld_CNT, EN, Sel, LdR, OE, Busy, Done, Error
   );

   modport slave (
      input  n, Ld_CNT, EN, Sel, LdR, OE,
      output GT12, GT1, RESULT
   );

endinterface

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, product register and the GT12/GT1 comparators.
module fact_dp
   import fact_pkg::*;
#(
   parameter int NW = 4
)(
   input  logic     CLK,
   input  logic     RST_N,
   fact_cu_if.slave bus
);

   logic [NW-1:0]    cnt;
   logic [RES_W-1:0] prod;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt  <= '0;
         prod <= '0;
      end else begin
         if (bus.Ld_CNT)  cnt <= bus.n;
         else if (bus.EN) cnt <= cnt - NW'(1);
         if (bus.LdR)
            prod <= (bus.Sel == SEL_ONE) ? RES_W'(1) : prod * RES_W'(cnt);
      end
   end

   assign bus.GT12   = int'(bus.n) > FACT_MAX_N;
   assign bus.GT1    = int'(cnt) > 1;
   assign bus.RESULT = bus.OE ? prod : '0;

endmodule

// File: rtl/fact_top.sv
// Integration wrapper: control unit plus datapath behind the host Go/Done port set.
module fact_top
   import fact_pkg::*;
#(
   parameter int NW = 4
)(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             Go,
   input  logic [NW-1:0]    n_in,
   output logic [RES_W-1:0] RESULT,
   output logic             Done,
   output logic             Error
);

   fact_cu_if #(.NW(NW)) bus ();

   assign bus.Go   = Go;
   assign bus.n_in = n_in;

   fact_cu #(.NW(NW)) u_cu (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.master)
   );

   fact_dp #(.NW(NW)) u_dp (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   assign RESULT = bus.RESULT;
   assign Done   = bus.Done;
   assign Error  = bus.Error;

endmodule

// File: rtl/fact_cu.sv
// Factorial control unit: sequences load, multiply loop and result release from Go/Done.
module fact_cu
   import fact_pkg::*;
#(
   parameter int NW = 4
)(
   input  logic      CLK,
   input  logic      RST_N,
   fact_cu_if.master bus
);

   fact_state_t   state, state_nxt;
   logic [NW-1:0] n_q;
   logic          cap_n;
   logic          ld_cnt, en, sel, ldr, oe, busy, done, error;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
         n_q   <= '0;
      end else begin
         state <= state_nxt;
         if (cap_n) n_q <= bus.n_in;
      end
   end

   // Control strobes depend only on state and the datapath flags, so they
   // settle well before the edge where the datapath samples them.
   always_comb begin
      state_nxt = state;
      cap_n     = 1'b0;
      ld_cnt    = 1'b0;
      en        = 1'b0;
      sel       = SEL_MULT;
      ldr       = 1'b0;
      oe        = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.Go) begin
               cap_n     = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy = 1'b1;
            sel  = SEL_ONE;
            if (bus.GT12) begin
               state_nxt = ST_ERR;
            end else begin
               ld_cnt    = 1'b1;
               ldr       = 1'b1;
               state_nxt = ST_MUL;
            end
         end
         ST_MUL: begin
            busy = 1'b1;
            if (bus.GT1) begin
               ldr = 1'b1;
               en  = 1'b1;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            oe   = 1'b1;
            done = 1'b1;
            if (!bus.Go) state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            error = 1'b1;
            if (!bus.Go) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.n      = n_q;
   assign bus.Ld_CNT = ld_cnt;
   assign bus.EN     = en;
   assign bus.Sel    = sel;
   assign bus.LdR    = ldr;
   assign bus.OE     = oe;
   assign bus.Busy   = busy;
   assign bus.Done   = done;
   assign bus.Error  = error;

endmodule

// File: tb/tb_fact_cu.sv
// Scoreboard bench for fact_cu driving the factorial datapath end to end.
module tb_fact_cu;
   import fact_pkg::*;

   localparam int NW = 4;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   fact_cu_if #(.NW(NW)) bus ();

   fact_cu #(.NW(NW)) u_dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.master)
   );

   fact_dp #(.NW(NW)) u_dp (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   typedef struct {
      int unsigned res;
      bit          err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   t0 = 0;
   bit   got_end = 0;
   int   busy_cnt = 0;
   bit   en_seen = 0, ld_seen = 0, oe_seen = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int unsigned fact_of(input int k);
      longint p = 1;
      for (int i = 2; i <= k; i++) p = p * i;
      return p[31:0];
   endfunction

   initial forever @(posedge CLK) cyc++;

   // Monitor: pops the scoreboard on the first cycle of Done or Error.
   initial begin
      exp_t e;
      bit   prev_done = 0, prev_err = 0;
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            if (bus.Busy) busy_cnt++;
            if (bus.EN) en_seen = 1;
            if (bus.Ld_CNT || bus.LdR) ld_seen = 1;
            if (bus.OE) oe_seen = 1;
            if ((bus.Done && !prev_done) || (bus.Error && !prev_err)) begin
               if (sb.size() == 0) begin
                  chk("unexpected_end", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("latency", cyc - t0, e.lat);
                  chk("error", bus.Error, e.err);
                  chk("done", bus.Done, !e.err);
                  chk("oe", bus.OE, !e.err);
                  chk("result", bus.RESULT, e.err ? 0 : e.res);
               end
               got_end = 1;
            end
         end
         prev_done = bus.Done;
         prev_err  = bus.Error;
      end
   end

   // Caller is positioned at a negedge; the next posedge is cycle 0.
   task automatic start(input int k, input bit hold);
      exp_t e;
      e.err = (k > 12);
      e.res = e.err ? 0 : fact_of(k);
      e.lat = e.err ? 2 : ((k < 1 ? 1 : k) + 2);
      sb.push_back(e);
      bus.n_in = NW'(k);
      bus.Go   = 1'b1;
      t0       = cyc;
      got_end  = 0;
      busy_cnt = 0;
      en_seen  = 0;
      ld_seen  = 0;
      oe_seen  = 0;
      if (!hold) begin
         @(negedge CLK);
         bus.Go = 1'b0;
      end
   endtask

   task automatic wait_end(input string tag, input int budget);
      int i = 0;
      while (!got_end && i < budget) begin
         @(posedge CLK);
         i++;
      end
      if (!got_end) chk({"timeout_", tag}, 0, 1);
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge CLK);
   endtask

   initial begin
      bit hold_bad, n_bad;
      int i;

      bus.Go   = 1'b1;
      bus.n_in = 4'd9;
      idle(2);
      #1;
      chk("reset_outputs", {bus.n, bus.Ld_CNT, bus.EN, bus.Sel, bus.LdR, bus.OE,
                            bus.Busy, bus.Done, bus.Error}, 0);
      bus.Go = 1'b0;
      idle(1);
      RST_N = 1'b1;
      idle(2);

      start(5, 0);
      wait_end("n5", 40);
      chk("busy_cycles_n5", busy_cnt, 6);
      idle(3);

      for (int k = 0; k <= 1; k++) begin
         start(k, 0);
         wait_end("n01", 40);
         chk("en_seen_n01", en_seen, 0);
         idle(3);
      end

      start(12, 0);
      wait_end("n12", 40);
      idle(3);

      start(13, 0);
      wait_end("n13", 40);
      chk("ld_seen_n13", ld_seen, 0);
      chk("oe_seen_n13", oe_seen, 0);
      chk("busy_cycles_n13", busy_cnt, 1);
      idle(3);

      // Go held through DONE must not retrigger.
      start(5, 1);
      wait_end("hold", 40);
      hold_bad = 0;
      repeat (20) begin
         @(negedge CLK);
         if (!bus.Done || bus.Busy || bus.Error) hold_bad = 1;
      end
      chk("hold_no_restart", hold_bad, 0);
      bus.Go = 1'b0;
      @(negedge CLK);
      chk("release_idle", {bus.Busy, bus.Done, bus.Error}, 0);
      start(4, 0);
      wait_end("n4", 40);
      idle(3);

      // Operand churn after capture must not reach n.
      start(6, 0);
      n_bad = 0;
      i = 0;
      while (!got_end && i < 40) begin
         @(negedge CLK);
         bus.n_in = NW'($urandom_range(0, 15));
         if (bus.n !== 4'd6) n_bad = 1;
         i++;
      end
      if (!got_end) chk("timeout_n6", 0, 1);
      chk("n_stable", n_bad, 0);
      bus.n_in = '0;
      idle(3);

      // Asynchronous reset in cycle 5 of n=10 aborts the run.
      start(10, 0);
      idle(4);
      chk("busy_before_rst", bus.Busy, 1);
      RST_N = 1'b0;
      #1;
      chk("midrun_reset_outputs", {bus.n, bus.Ld_CNT, bus.EN, bus.Sel, bus.LdR, bus.OE,
                                   bus.Busy, bus.Done, bus.Error, bus.RESULT}, 0);
      sb.delete();
      idle(2);
      RST_N = 1'b1;
      idle(2);
      start(3, 0);
      wait_end("n3", 40);
      idle(3);

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fact_cu.md
# fact_cu

Control unit for the iterative factorial datapath: it sequences counter load, register initialisation, the multiply loop and result release from a Go/Done handshake. It sits directly upstream of the factorial datapath. It latches the operand, drives `Ld_CNT`/`Sel`/`EN`/`LdR`/`OE`, and consumes the datapath status flags `GT12` (operand > 12, overflow) and `GT1` (counter > 1).

## Interface
Parameters:
- `NW`, 4: operand width (`n`).

Ports:
- `CLK`, input, 1: single clock; all state changes on its rising edge.
- `RST_N`, input, 1: asynchronous active-low reset.
- `Go`, input, 1: start request, level-sensitive, from the host.
- `n_in`, input, NW: operand from the host, sampled when a start is accepted.
- `GT12`, input, 1: datapath flag, latched `n` > 12.
- `GT1`, input, 1: datapath flag, counter value > 1.
- `n`, output, NW: latched operand to the datapath counter and comparator.
- `Ld_CNT`, output, 1: load the counter from `n`.
- `EN`, output, 1: counter decrement enable.
- `Sel`, output, 1: loop mux select; 1 selects constant 1, 0 selects the multiplier output.
- `LdR`, output, 1: load the product register.
- `OE`, output, 1: output mux enable; `RESULT` is valid only while high.
- `Busy`, output, 1: computation in progress.
- `Done`, output, 1: result valid; held until `Go` is released.
- `Error`, output, 1: operand > 12 (32-bit overflow); held until `Go` is released.

## Operation
States: IDLE, LOAD, MUL, DONE, ERR. The encoding comes from the shared package.
- **IDLE**
  - All control outputs are 0.
  - `Go`=1 → capture `n_in` into `n`, go to LOAD.
- **LOAD**
  - Drives `Ld_CNT`=1, `Sel`=1, `LdR`=1, `Busy`=1.
  - `GT12`=1 → ERR. Loads are suppressed that cycle (`Ld_CNT`=`LdR`=0); the datapath is not disturbed.
  - Otherwise → MUL.
- **MUL**
  - `Busy`=1.
  - `GT1`=1 → `Sel`=0, `LdR`=1, `EN`=1 (REG ← REG×CNT, CNT ← CNT−1), stay in MUL.
  - `GT1`=0 → no loads, go to DONE.
- **DONE**
  - `OE`=1, `Done`=1, `Busy`=0.
  - Stays while `Go`=1. `Go`=0 → IDLE.
- **ERR**
  - `Error`=1, `OE`=0.
  - Stays while `Go`=1. `Go`=0 → IDLE.

Rules:
- A new start requires `Go` to be low for at least one cycle after DONE/ERR. `Go` held high never retriggers.
- `n_in` is ignored outside IDLE. `n` is stable from LOAD through DONE/ERR.
- `Go` dropping in LOAD or MUL is ignored; the computation completes.
- n=0 and n=1 both finish with RESULT=1, since REG is preloaded to 1 and no MUL iteration fires.
- Exactly one of `Busy`, `Done`, `Error` is high outside IDLE. All are low in IDLE.
- `Ld_CNT`, `EN`, `LdR` and `Sel` are Moore/Mealy combinational from state plus `GT12`/`GT1`. They must be glitch-free at the clock edge, which is the datapath's only sampling point.

## Timing
- Reset (`RST_N`=0, asynchronous): state=IDLE, `n`=0, all outputs 0. This takes effect immediately and also aborts a computation mid-operation.
- Release is synchronous to `CLK`. The first `Go` is sampled on the first edge after deassertion.
- Cycle 0 is the edge where `Go` is sampled in IDLE.
  - Cycle 1: LOAD.
  - Cycles 2…: MUL.
- For n=k ≤ 12: MUL performs max(k−1,0) multiplying cycles plus one exit cycle.
  - `Done` first high in cycle max(k,1)+2. Example: n=5 → cycle 7.
- For n > 12: `Error` is high in cycle 2.
- Latency from `Go` low in DONE/ERR to IDLE is 1 cycle. The earliest next accepted `Go` is 2 cycles after the release.

## Structure
- Shared package `fact_pkg` holds:
  - the state typedef/localparams (IDLE, LOAD, MUL, DONE, ERR);
  - `FACT_MAX_N` = 12;
  - the `Sel` encoding constants (`SEL_ONE`=1, `SEL_MULT`=0).
- One sub-module is natural: `fact_top`, the integration wrapper instantiating `fact_cu` plus the datapath, with ports `CLK`, `RST_N`, `Go`, `n_in`, `RESULT`, `Done`, `Error`. It is the verification target for the end-to-end tests.
- `fact_cu` itself is one state register, one operand register and combinational next-state/output logic.

## Test plan
- Reset mid-MUL (n=10, pull `RST_N` low in cycle 5) → all outputs 0 immediately, state IDLE; a fresh `Go` with n=3 gives RESULT=6.
- n=5, `Go` pulsed high → `Done` in cycle 7, RESULT=120 with `OE`=1; `Busy` high in cycles 1–6 only.
- n=0 and n=1 → `Done` in cycle 3, RESULT=1; `EN` never asserted.
- n=12 → RESULT=479001600, `Error`=0. n=13 → `Error` in cycle 2, `Ld_CNT`/`LdR` never asserted, `OE` stays 0.
- `Go` held high through DONE for 20 cycles → no restart. `Go` low 1 cycle then high with n=4 → RESULT=24.
- `n_in` changed every cycle during MUL (n=6 latched) → `n` output stays 6, RESULT=720.
